des_iterative: RTL and testbench

DES_ITERATIVE -- requirements
Module: des_iterative

---
 rtl/des_iterative.sv | 240 ++++++++++++++++++++++++
 tb/tb_des_iterative.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/des_iterative.sv
// des_iterative: iterative DES core, ROUNDS_PER_CYCLE Feistel rounds per clock.
// Round keys are derived on the fly from the rotating C/D registers.
// Optional feature macro: DES_ITERATIVE_DECRYPT_EN (enables decryption mode).
module des_iterative #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] in_data,
    input  logic [64:1] key,
    input  logic        decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] out_data,
    output logic        busy
);

    // Only divisors of 16 give a whole number of cycles per block.
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
        $error("des_iterative: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [3:0] STEP = 4'(ROUNDS_PER_CYCLE % 16);

    // Tables use DES bit numbering (1 = MSB).
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int IPI_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
    // S-boxes flattened row-major: index = {b1,b6} * 16 + {b2..b5}.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Vector bit (W - n) holds DES bit n in every function below.
    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 1; j <= 64; j++) y[64-j] = x[64-IP_T[j-1]];
        return y;
    endfunction

    function automatic logic [63:0] ipi_f(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 1; j <= 64; j++) y[64-j] = x[64-IPI_T[j-1]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 1; j <= 56; j++) y[56-j] = x[64-PC1_T[j-1]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        logic [47:0] y;
        for (int j = 1; j <= 48; j++) y[48-j] = x[56-PC2_T[j-1]];
        return y;
    endfunction

    function automatic logic [47:0] e_f(input logic [31:0] x);
        logic [47:0] y;
        for (int j = 1; j <= 48; j++) y[48-j] = x[32-E_T[j-1]];
        return y;
    endfunction

    function automatic logic [31:0] p_f(input logic [31:0] x);
        logic [31:0] y;
        for (int j = 1; j <= 32; j++) y[32-j] = x[32-P_T[j-1]];
        return y;
    endfunction

    function automatic logic [31:0] f_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  b;
        x = e_f(r) ^ k;
        for (int i = 0; i < 8; i++) begin
            b = x[47-6*i -: 6];
            s[31-4*i -: 4] = SBOX[i][{b[5], b[0], b[4:1]}];
        end
        return p_f(s);
    endfunction

    // Encrypt schedule: single left shift on rounds 1, 2, 9, 16 (rnd is 0-based).
    function automatic logic [27:0] rotl_f(input logic [27:0] c, input logic [3:0] rnd);
        if (rnd == 4'd0 || rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15)
            return {c[26:0], c[27]};
        return {c[25:0], c[27:26]};
    endfunction

`ifdef DES_ITERATIVE_DECRYPT_EN
    // Decrypt schedule walks K16..K1: no shift before round 1, then the
    // encrypt shifts in reverse order as right rotations.
    function automatic logic [27:0] rotr_f(input logic [27:0] c, input logic [3:0] rnd);
        if (rnd == 4'd0)
            return c;
        if (rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15)
            return {c[0], c[27:1]};
        return {c[1:0], c[27:2]};
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt_q;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
`ifdef DES_ITERATIVE_DECRYPT_EN
    logic        mode_q;
`else
    logic        unused_decrypt;
    assign unused_decrypt = decrypt;
`endif

    // PC-1 drops the key parity bits.
    logic unused_parity;
    assign unused_parity = ^{key[57], key[49], key[41], key[33],
                             key[25], key[17], key[9], key[1]};

    // Combinational cascade of ROUNDS_PER_CYCLE rounds starting at round cnt_q.
    logic [31:0] l_s [ROUNDS_PER_CYCLE+1];
    logic [31:0] r_s [ROUNDS_PER_CYCLE+1];
    logic [27:0] c_s [ROUNDS_PER_CYCLE+1];
    logic [27:0] d_s [ROUNDS_PER_CYCLE+1];

    assign l_s[0] = l_q;
    assign r_s[0] = r_q;
    assign c_s[0] = c_q;
    assign d_s[0] = d_q;

    for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
        logic [3:0] rnd;
        assign rnd = cnt_q + 4'(k);
`ifdef DES_ITERATIVE_DECRYPT_EN
        assign c_s[k+1] = mode_q ? rotr_f(c_s[k], rnd) : rotl_f(c_s[k], rnd);
        assign d_s[k+1] = mode_q ? rotr_f(d_s[k], rnd) : rotl_f(d_s[k], rnd);
`else
        assign c_s[k+1] = rotl_f(c_s[k], rnd);
        assign d_s[k+1] = rotl_f(d_s[k], rnd);
`endif
        assign l_s[k+1] = r_s[k];
        assign r_s[k+1] = l_s[k] ^ f_f(r_s[k], pc2_f({c_s[k+1], d_s[k+1]}));
    end

    // Job FSM: accept, iterate rounds, hold result until the sink takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            cnt_q     <= '0;
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
`ifdef DES_ITERATIVE_DECRYPT_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    {l_q, r_q} <= ip_f(in_data);
                    {c_q, d_q} <= pc1_f(key);
`ifdef DES_ITERATIVE_DECRYPT_EN
                    mode_q     <= decrypt;
`endif
                    cnt_q      <= '0;
                    state      <= RUN;
                    in_ready   <= 1'b0;
                    busy       <= 1'b1;
                end
                RUN: begin
                    l_q   <= l_s[ROUNDS_PER_CYCLE];
                    r_q   <= r_s[ROUNDS_PER_CYCLE];
                    c_q   <= c_s[ROUNDS_PER_CYCLE];
                    d_q   <= d_s[ROUNDS_PER_CYCLE];
                    cnt_q <= cnt_q + STEP;
                    if (4'(cnt_q + STEP) == 4'd0) begin
                        // Final swap: preoutput is R16 followed by L16.
                        out_data  <= ipi_f({r_s[ROUNDS_PER_CYCLE], l_s[ROUNDS_PER_CYCLE]});
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_iterative.sv
// tb_des_iterative: directed DES vectors against all five ROUNDS_PER_CYCLE variants.
module tb_des_iterative;

    localparam int NDUT = 5;

    logic        clk, rst, in_valid, out_ready, decrypt;
    logic [64:1] in_data, key;
    logic        ir [NDUT];
    logic        ov [NDUT];
    logic        bz [NDUT];
    logic [64:1] od [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        des_iterative #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]),
            .in_data(in_data), .key(key), .decrypt(decrypt),
            .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]), .busy(bz[g]));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [64:1] key;
        logic [64:1] data;
        logic        dec;
        logic [64:1] exp;
    } vec_t;

    task automatic chk64(input string nm, input logic [64:1] act, input logic [64:1] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkint(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic scramble();
        in_data = {$urandom, $urandom};
        key     = {$urandom, $urandom};
        decrypt = 1'($urandom);
    endtask

    // Present one job; caller is away from a clock edge. Returns #1 after accept.
    task automatic issue(input vec_t v);
        in_valid = 1'b1;
        in_data  = v.data;
        key      = v.key;
        decrypt  = v.dec;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        for (int i = 0; i < NDUT; i++) begin
            chk1($sformatf("%s_busy_rpc%0d", v.name, 1 << i), bz[i], 1'b1);
            chk1($sformatf("%s_inrdy_rpc%0d", v.name, 1 << i), ir[i], 1'b0);
        end
    endtask

    // Count edges until each variant raises out_valid, then check latency and data.
    task automatic collect(input logic [64:1] exp, input string nm, input bit release_out);
        int lat [NDUT];
        bit seen [NDUT];
        for (int i = 0; i < NDUT; i++) begin
            lat[i]  = 0;
            seen[i] = 1'b0;
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NDUT; i++)
                if (!seen[i] && ov[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = cyc;
                end
        end
        for (int i = 0; i < NDUT; i++) begin
            chkint($sformatf("%s_lat_rpc%0d", nm, 1 << i), lat[i], 16 >> i);
            chk64($sformatf("%s_data_rpc%0d", nm, 1 << i), od[i], exp);
        end
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int i = 0; i < NDUT; i++) begin
                chk1($sformatf("%s_idle_rdy_rpc%0d", nm, 1 << i), ir[i], 1'b1);
                chk1($sformatf("%s_idle_ov_rpc%0d", nm, 1 << i), ov[i], 1'b0);
                chk1($sformatf("%s_idle_busy_rpc%0d", nm, 1 << i), bz[i], 1'b0);
            end
        end
    endtask

    vec_t vecs [7];
    int   ov_seen;

    initial begin
        vecs[0] = '{"fips",  64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
        vecs[1] = '{"zero",  64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
        vecs[2] = '{"key0",  64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};
        vecs[3] = '{"keyF",  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h7359B2163E4EDC58};
        vecs[4] = '{"nowis", 64'h0123456789ABCDEF, 64'h4E6F772069732074, 1'b0, 64'h3FA40E8A984D4815};
`ifdef DES_ITERATIVE_DECRYPT_EN
        vecs[5] = '{"dec1",  64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
        vecs[6] = '{"dec2",  64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};
`else
        // Without decryption support the mode bit is ignored: result is encryption.
        vecs[5] = '{"dec1",  64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b1, 64'h85E813540F0AB405};
        vecs[6] = '{"dec2",  64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b1, 64'h0000000000000000};
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; key = '0; decrypt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk1($sformatf("rst_inrdy_rpc%0d", 1 << i), ir[i], 1'b1);
            chk1($sformatf("rst_ov_rpc%0d", 1 << i), ov[i], 1'b0);
            chk1($sformatf("rst_busy_rpc%0d", 1 << i), bz[i], 1'b0);
            chk64($sformatf("rst_data_rpc%0d", 1 << i), od[i], 64'h0);
        end
        // First job is offered at the very edge where reset is already low.
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            issue(vecs[v]);
            collect(vecs[v].exp, vecs[v].name, 1'b1);
        end

        // Hold the result for 10 cycles with in_valid pulsing.
        issue(vecs[0]);
        collect(vecs[0].exp, "hold", 1'b0);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            scramble();
            @(posedge clk); #1;
            for (int i = 0; i < NDUT; i++) begin
                chk1($sformatf("hold%0d_ov_rpc%0d", c, 1 << i), ov[i], 1'b1);
                chk1($sformatf("hold%0d_rdy_rpc%0d", c, 1 << i), ir[i], 1'b0);
                chk64($sformatf("hold%0d_data_rpc%0d", c, 1 << i), od[i], vecs[0].exp);
            end
        end
        // Handshake with the next job already waiting: IDLE, then accept one edge later.
        in_valid  = 1'b1;
        in_data   = vecs[1].data;
        key       = vecs[1].key;
        decrypt   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk1("b2b_idle_rdy", ir[0], 1'b1);
        chk1("b2b_idle_ov", ov[0], 1'b0);
        issue(vecs[1]);
        collect(vecs[1].exp, "b2b", 1'b1);

        // Reset in the middle of a job (RPC=1 counter at 7).
        issue(vecs[0]);
        repeat (7) @(posedge clk);
        #1;
        chk1("mid_busy", bz[0], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk1($sformatf("midrst_inrdy_rpc%0d", 1 << i), ir[i], 1'b1);
            chk1($sformatf("midrst_ov_rpc%0d", 1 << i), ov[i], 1'b0);
            chk1($sformatf("midrst_busy_rpc%0d", 1 << i), bz[i], 1'b0);
            chk64($sformatf("midrst_data_rpc%0d", 1 << i), od[i], 64'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ov_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NDUT; i++)
                if (ov[i] || bz[i]) ov_seen++;
        end
        chkint("abandoned_job_activity", ov_seen, 0);
        issue(vecs[4]);
        collect(vecs[4].exp, "after_rst", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
